// File: rtl/btn_entry_sequencer.sv
// Button front end for the hex-digit entry datapath: synchronise, debounce and
// arbitrate the four navigation buttons, then emit one-cycle command strobes.
module btn_entry_sequencer #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          REPEAT_DELAY    = 50000000,
    parameter int          REPEAT_RATE     = 10000000,
    parameter logic [3:0]  REPEAT_MASK     = 4'b1100,
    parameter int          CNT_W           = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       BTNL,
    input  logic       BTNR,
    input  logic       BTNU,
    input  logic       BTND,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic       cmd_repeat,
    output logic       held
);

    // cmd_valid is a one-cycle strobe with no ready: the datapath must take the
    // command in the cycle it is presented; cmd_code/cmd_repeat are 0 otherwise.

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LD = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LD  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    logic [3:0]       raw;
    logic [3:0]       sync_meta;
    logic [3:0]       sync_q;
    logic [3:0]       db;
    logic [CNT_W-1:0] db_cnt [4];

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       owner;
    logic [1:0]       owner_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_nxt;
    logic             valid_nxt;
    logic [1:0]       code_nxt;
    logic             repeat_nxt;

    assign raw = {BTND, BTNU, BTNR, BTNL};

    // Fixed priority L > R > U > D.
    function automatic logic [1:0] pick_owner(input logic [3:0] b);
        logic [1:0] r;
        r = 2'd0;
        if (b[0])      r = 2'd0;
        else if (b[1]) r = 2'd1;
        else if (b[2]) r = 2'd2;
        else if (b[3]) r = 2'd3;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 4'b0000;
            sync_q    <= 4'b0000;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // A level change is accepted only after the new value survives the full
    // count; any return to the old level restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_q[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LIMIT) begin
                    db[i]     <= sync_q[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            rep_cnt    <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 2'd0;
            cmd_repeat <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rep_cnt    <= rep_cnt_nxt;
            cmd_valid  <= valid_nxt;
            cmd_code   <= code_nxt;
            cmd_repeat <= repeat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rep_cnt_nxt = rep_cnt;
        valid_nxt   = 1'b0;
        code_nxt    = 2'd0;
        repeat_nxt  = 1'b0;
        if (!enable) begin
            // Leaving entry mode also cancels any strobe due on this edge.
            state_nxt = LOCKOUT;
        end else begin
            case (state)
                IDLE: begin
                    if (|db) begin
                        owner_nxt   = pick_owner(db);
                        valid_nxt   = 1'b1;
                        code_nxt    = pick_owner(db);
                        rep_cnt_nxt = DELAY_LD;
                        state_nxt   = HOLD;
                    end
                end
                HOLD: begin
                    if (!db[owner]) begin
                        state_nxt = LOCKOUT;
                    end else if (REPEAT_MASK[owner]) begin
                        if (rep_cnt == CNT_ONE) begin
                            valid_nxt   = 1'b1;
                            code_nxt    = owner;
                            repeat_nxt  = 1'b1;
                            rep_cnt_nxt = RATE_LD;
                        end else begin
                            rep_cnt_nxt = rep_cnt - CNT_ONE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (db == 4'b0000) state_nxt = IDLE;
                end
                default: state_nxt = LOCKOUT;
            endcase
        end
    end

    assign held = (state == HOLD) && db[owner];

endmodule

// File: tb/tb_btn_entry_sequencer.sv
// Randomised scoreboard bench for btn_entry_sequencer with small timing parameters.
module tb_btn_entry_sequencer;

  localparam int         DB = 4;
  localparam int         RD = 20;
  localparam int         RR = 8;
  localparam logic [3:0] RM = 4'b1100;
  localparam int         EW = 35;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       BTNL = 1'b0;
  logic       BTNR = 1'b0;
  logic       BTNU = 1'b0;
  logic       BTND = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_repeat;
  logic       held;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int strobes = 0;
  int last_cyc = 0;
  logic [1:0] last_code = 2'd0;
  logic       last_rep = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  // reference model state
  logic [3:0] m_s1 = 4'b0;
  logic [3:0] m_s2 = 4'b0;
  logic [3:0] m_db = 4'b0;
  int         m_run[4] = '{0, 0, 0, 0};
  int         m_owner = -1;
  bit         m_locked = 1'b0;
  int         m_next_rep = 0;
  logic [1:0] m_own2;
  logic       m_held;

  btn_entry_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .REPEAT_MASK(RM),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .BTNL(BTNL),
    .BTNR(BTNR),
    .BTNU(BTNU),
    .BTND(BTND),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .cmd_repeat(cmd_repeat),
    .held(held)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each edge: decide the command from the pre-edge debounced levels, then
  // advance the debouncer (a level is accepted after DB+1 disagreeing samples)
  // and the two-stage synchroniser.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1 = 4'b0;
      m_s2 = 4'b0;
      m_db = 4'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_owner = -1;
      m_locked = 1'b0;
      m_next_rep = 0;
    end else begin
      if (!enable) begin
        m_owner = -1;
        m_locked = 1'b1;
      end else if (m_owner >= 0) begin
        if (!m_db[m_owner]) begin
          m_owner = -1;
          m_locked = 1'b1;
        end else if (RM[m_owner] && cyc == m_next_rep) begin
          m_own2 = m_owner[1:0];
          exp_q.push_back({cyc, 1'b1, m_own2});
          m_next_rep = cyc + RR;
        end
      end else if (m_locked) begin
        if (m_db == 4'b0) m_locked = 1'b0;
      end else if (m_db != 4'b0) begin
        for (int i = 3; i >= 0; i--) if (m_db[i]) m_owner = i;
        m_own2 = m_owner[1:0];
        exp_q.push_back({cyc, 1'b0, m_own2});
        m_next_rep = cyc + RD;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            m_db[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {BTND, BTNU, BTNR, BTNL};
    end
  end

  // A strobe scheduled on the edge just before reset rises is cancelled by it.
  always @(posedge rst) exp_q.delete();

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      tests++;
      if (cmd_valid || cmd_code != 2'd0 || cmd_repeat || held) begin
        fails++;
        $display("FAIL reset_outputs: got valid=%0b code=%0d rep=%0b held=%0b, want all 0",
                 cmd_valid, cmd_code, cmd_repeat, held);
      end
    end else begin
      if (cmd_valid) begin
        strobes++;
        last_cyc = cyc;
        last_code = cmd_code;
        last_rep = cmd_repeat;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got code=%0d rep=%0b at cycle %0d, want no strobe",
                   cmd_code, cmd_repeat, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[34:3] != cyc || mon_e[1:0] != cmd_code || mon_e[2] != cmd_repeat) begin
            fails++;
            $display("FAIL strobe: got code=%0d rep=%0b cycle=%0d, want code=%0d rep=%0b cycle=%0d",
                     cmd_code, cmd_repeat, cyc, mon_e[1:0], mon_e[2], mon_e[34:3]);
          end
        end
      end else begin
        tests++;
        if (cmd_code != 2'd0 || cmd_repeat) begin
          fails++;
          $display("FAIL idle_fields: got code=%0d rep=%0b with valid=0, want 0/0",
                   cmd_code, cmd_repeat);
        end
        if (exp_q.size() > 0 && int'(exp_q[0][34:3]) <= cyc) begin
          mon_e = exp_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_strobe: got none at cycle %0d, want code=%0d rep=%0b",
                   cyc, mon_e[1:0], mon_e[2]);
        end
      end
      m_held = (m_owner >= 0) ? m_db[m_owner] : 1'b0;
      tests++;
      if (held != m_held) begin
        fails++;
        $display("FAIL held: got %0b at cycle %0d, want %0b", held, cyc, m_held);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic set_btns(input logic [3:0] b);
    {BTND, BTNU, BTNR, BTNL} = b;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int rise;
    logic [3:0] b;

    wait_cycles(3);
    rst = 1'b0;
    enable = 1'b1;
    wait_cycles(5);

    // 1: clean single press
    s0 = strobes;
    rise = cyc;
    BTNU = 1'b1;
    wait_cycles(15);
    check_int("t1_latency", last_cyc - rise, 8);
    check_int("t1_code", int'(last_code), 2);
    check_int("t1_rep", int'(last_rep), 0);
    BTNU = 1'b0;
    wait_cycles(12);
    check_int("t1_count", strobes - s0, 1);
    wait_cycles($urandom_range(5, 15));

    // 2: bouncing press
    s0 = strobes;
    for (int k = 0; k < 3; k++) begin
      BTNL = 1'b1;
      wait_cycles(2);
      BTNL = 1'b0;
      wait_cycles(2);
    end
    check_int("t2_bounce_count", strobes - s0, 0);
    rise = cyc;
    BTNL = 1'b1;
    wait_cycles(20);
    check_int("t2_latency", last_cyc - rise, 8);
    check_int("t2_code", int'(last_code), 0);
    BTNL = 1'b0;
    wait_cycles(12);
    check_int("t2_count", strobes - s0, 1);
    wait_cycles($urandom_range(5, 15));

    // 3: auto-repeat on D, none on L
    s0 = strobes;
    BTND = 1'b1;
    wait_cycles(60);
    BTND = 1'b0;
    wait_cycles(12);
    check_int("t3_d_count", strobes - s0, 6);
    check_int("t3_d_code", int'(last_code), 3);
    check_int("t3_d_rep", int'(last_rep), 1);
    s0 = strobes;
    BTNL = 1'b1;
    wait_cycles(60);
    BTNL = 1'b0;
    wait_cycles(12);
    check_int("t3_l_count", strobes - s0, 1);
    wait_cycles($urandom_range(5, 15));

    // 4: simultaneous R+U, owner release keeps lockout
    s0 = strobes;
    BTNR = 1'b1;
    BTNU = 1'b1;
    wait_cycles(15);
    check_int("t4_first_count", strobes - s0, 1);
    check_int("t4_first_code", int'(last_code), 1);
    BTNR = 1'b0;
    wait_cycles(30);
    BTNU = 1'b0;
    wait_cycles(12);
    check_int("t4_lockout_count", strobes - s0, 1);
    BTNU = 1'b1;
    wait_cycles(15);
    BTNU = 1'b0;
    wait_cycles(12);
    check_int("t4_second_count", strobes - s0, 2);
    check_int("t4_second_code", int'(last_code), 2);
    wait_cycles($urandom_range(5, 15));

    // 5: enable low blocks, raising enable needs a fresh press
    s0 = strobes;
    enable = 1'b0;
    BTNU = 1'b1;
    wait_cycles(15);
    enable = 1'b1;
    wait_cycles(15);
    check_int("t5_blocked_count", strobes - s0, 0);
    BTNU = 1'b0;
    wait_cycles(12);
    BTNU = 1'b1;
    wait_cycles(15);
    BTNU = 1'b0;
    wait_cycles(12);
    check_int("t5_repress_count", strobes - s0, 1);
    wait_cycles($urandom_range(5, 15));

    // 6: reset mid repeat sequence
    s0 = strobes;
    rise = cyc;
    BTND = 1'b1;
    wait_cycles(8 + 25);
    rst = 1'b1;
    #1;
    check_int("t6_rst_valid", int'(cmd_valid), 0);
    check_int("t6_rst_code", int'(cmd_code), 0);
    check_int("t6_rst_rep", int'(cmd_repeat), 0);
    check_int("t6_rst_held", int'(held), 0);
    check_int("t6_pre_rst_count", strobes - s0, 2);
    wait_cycles(2);
    rst = 1'b0;
    rise = cyc;
    wait_cycles(25);
    check_int("t6_fresh_latency", last_cyc - rise, 8);
    check_int("t6_fresh_rep", int'(last_rep), 0);
    BTND = 1'b0;
    wait_cycles(12);

    // random soak against the model
    for (int it = 0; it < 250; it++) begin
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) b = 4'b0000;
      set_btns(b);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        wait_cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      wait_cycles($urandom_range(1, 30));
    end

    set_btns(4'b0000);
    enable = 1'b1;
    wait_cycles(20);
    check_int("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_entry_sequencer.md
Name: btn_entry_sequencer

Overview:
Front-end controller for the hex-digit entry datapath on the Nexys4 board. It synchronises and debounces the four navigation buttons (BTNL/BTNR/BTNU/BTND) and arbitrates simultaneous presses by fixed priority. It then issues single-cycle command pulses to the entry datapath, with optional auto-repeat while a button is held. It replaces per-datapath ad-hoc lockout counters with one scheduler that owns the buttons.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed before a debounced level changes (10 ms at 100 MHz)
REPEAT_DELAY, 50000000, cycles from the initial pulse to the first auto-repeat pulse
REPEAT_RATE, 10000000, cycles between later auto-repeat pulses
REPEAT_MASK, 4'b1100, per-button auto-repeat enable; bit0=L, bit1=R, bit2=U, bit3=D
CNT_W, 27, width of the debounce and repeat counters; must hold the largest count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  entry mode active; when low, no commands are issued
BTNL  in  1  raw button, cursor left
BTNR  in  1  raw button, cursor right
BTNU  in  1  raw button, increment digit
BTND  in  1  raw button, decrement digit
cmd_valid  out  1  single-cycle command strobe
cmd_code  out  2  0=L, 1=R, 2=U, 3=D; valid only while cmd_valid=1, otherwise 0
cmd_repeat  out  1  1 when the current strobe is an auto-repeat; 0 otherwise
held  out  1  owning button is currently held (debounced)

Behaviour:
- Reset (async, rst=1): synchroniser flops, debounced levels, counters, FSM(=IDLE), cmd_valid, cmd_code, cmd_repeat and held all go to 0 immediately. A button still held when rst falls is treated as a fresh press.
- Synchroniser: 2 flip-flops per button; sync[i] lags the raw input by 2 clock edges.
- Debounce, per button: a counter increments while sync[i] != db[i] and clears whenever they are equal. When the counter reaches DEBOUNCE_CYCLES, db[i] takes sync[i] and the counter clears. Any bounce restarts the count.
- Press latency: raw high sampled at edge 0 -> db high after edge 2+DEBOUNCE_CYCLES -> cmd_valid high for the single cycle after edge DEBOUNCE_CYCLES+3.
- FSM states are IDLE, HOLD, LOCKOUT.
- IDLE, when enable=1 and any db=1: pick the owner by priority L>R>U>D. Register cmd_valid=1, cmd_code=owner, cmd_repeat=0. Load the repeat counter with REPEAT_DELAY. Go to HOLD.
- IDLE, when enable=0: go to LOCKOUT.
- HOLD: held=db[owner].
  - If db[owner]=0, go to LOCKOUT.
  - Else, if REPEAT_MASK[owner]=1, decrement the repeat counter. When it expires (counter was 1), strobe cmd_valid=1, cmd_code=owner, cmd_repeat=1 and reload REPEAT_RATE. Repeat pulses fall exactly REPEAT_DELAY after the initial pulse, then every REPEAT_RATE.
  - Non-owner buttons are ignored in HOLD.
- LOCKOUT: no strobes. Go to IDLE only when enable=1 and all four db=0. Owner release with another button still held therefore yields no new command until everything is released.
- enable falling in any state: go to LOCKOUT on the next edge and suppress any strobe scheduled for that edge. A pulse already registered completes its single cycle.
- Simultaneous events: debounced rises on the same cycle resolve by priority, and only one strobe is issued. cmd_valid is never high for two consecutive cycles.
- Counter arithmetic is unsigned and saturating-free. Parameters are guaranteed ≥2 and < 2^CNT_W; no wrap-around occurs.

Test Plan:
(Parameters overridden to DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.)
1. enable=1; BTNU clean high for 15 cycles -> exactly one strobe: cmd_code=2, cmd_repeat=0, held high 7 edges after the raw rise. held=1 until debounced release; no further strobes.
2. BTNL toggles every 2 cycles for 12 cycles, then stays high -> exactly one strobe, cmd_code=0, 7 edges after the final rise; no strobe during bouncing.
3. BTND held 60 cycles -> strobes at t0 (repeat=0), then t0+20, t0+28, t0+36, t0+44, t0+52 (repeat=1, code=3). BTNL held 60 cycles -> only the t0 strobe.
4. BTNR and BTNU rise on the same cycle -> one strobe with cmd_code=1. Release BTNR, keep BTNU high 30 cycles -> no strobe. Release all, then press BTNU -> new strobe with cmd_code=2.
5. enable=0 while BTNU is pressed -> no strobe. Raise enable with BTNU still held -> no strobe until BTNU is released and pressed again.
6. rst pulsed at t0+25 during the BTND repeat sequence -> all outputs 0 immediately. With BTND still held after rst falls -> fresh strobe (repeat=0) 7 edges later.
